// File: rtl/clock_disp_pkg.sv
// Shared constants and helpers for the clock display path.
// Used by display_scan_ctrl and scan_prescaler.
package clock_disp_pkg;

   localparam int         NUM_DIGITS = 6;
   localparam logic [3:0] POS_BLANK  = 4'hF;
   localparam logic [3:0] BCD_MAX    = 4'd9;

   // Prescaler counter width; a divide-by-1 still needs one bit.
   function automatic int presc_width(input int div);
      int w;
      w = $clog2(div);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Free-running divider: counts 0..TICK_DIV-1 while enabled.
// Ports: clk, rst (sync, active-high), en, tick (high on last count).
module scan_prescaler
   import clock_disp_pkg::*;
#(
   parameter int TICK_DIV = 50000
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic tick
);

   localparam int           W    = presc_width(TICK_DIV);
   localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

   logic [W-1:0] cnt;

   assign tick = en && (cnt == LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
      end
   end

endmodule

// File: rtl/display_scan_ctrl.sv
// Six-digit display scanner: walks positions and presents the snapshot digit.
// Ports: clk, rst, en, digits_in[23:0], blank_lz -> bcd_pos, bcd_digit, blank, frame_start.
module display_scan_ctrl #(
   parameter int TICK_DIV   = 50000,
   parameter int NUM_DIGITS = clock_disp_pkg::NUM_DIGITS
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic [23:0] digits_in,
   input  logic        blank_lz,
   output logic [3:0]  bcd_pos,
   output logic [3:0]  bcd_digit,
   output logic        blank,
   output logic        frame_start
);

   import clock_disp_pkg::*;

   localparam logic [2:0] LAST_POS = 3'(NUM_DIGITS - 1);

   logic        tick;
   logic [2:0]  pos_q;
   // 8 digit slots; slots above 5 stay zero since only 24 bits come in.
   logic [31:0] snap;
   logic        load_pend;
   logic        fs_pend;
   logic        wrap;
   logic [3:0]  d;
   logic        blank_nx;

   scan_prescaler #(
      .TICK_DIV(TICK_DIV)
   ) u_presc (
      .clk (clk),
      .rst (rst),
      .en  (en),
      .tick(tick)
   );

   // Position is held while the first snapshot loads, so the
   // first frame always starts from position 0 with real data.
   assign wrap = tick && !load_pend && (pos_q == LAST_POS);

   always_comb begin
      d        = snap[{pos_q, 2'b00} +: 4];
      blank_nx = (d > BCD_MAX)
               | (blank_lz & (pos_q == LAST_POS) & (d == 4'd0));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pos_q       <= '0;
         snap        <= '0;
         load_pend   <= 1'b1;
         fs_pend     <= 1'b0;
         bcd_pos     <= '0;
         bcd_digit   <= '0;
         blank       <= 1'b0;
         frame_start <= 1'b0;
      end else if (en) begin
         load_pend <= 1'b0;
         if (load_pend || wrap) begin
            snap <= 32'(digits_in);
         end
         if (tick && !load_pend) begin
            pos_q <= wrap ? 3'd0 : pos_q + 3'd1;
         end
         // Position 0 of the new frame reaches the outputs one
         // enabled cycle after the load/wrap, so delay the pulse.
         fs_pend     <= load_pend | wrap;
         frame_start <= fs_pend;
         blank       <= blank_nx;
         bcd_pos     <= blank_nx ? POS_BLANK : {1'b0, pos_q};
         bcd_digit   <= blank_nx ? 4'h0 : d;
      end
   end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Scoreboard bench for display_scan_ctrl with TICK_DIV=4.
// Expected display events are queued; a monitor pops on each output change.
module tb_display_scan_ctrl;

   typedef struct packed {
      logic [3:0] pos;
      logic [3:0] dig;
      logic       blk;
      logic       fs;
      int         dwell;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b1;
   logic [23:0] digits_in = 24'h0;
   logic        blank_lz = 1'b0;
   logic [3:0]  bcd_pos;
   logic [3:0]  bcd_digit;
   logic        blank;
   logic        frame_start;

   int total = 0;
   int bad = 0;
   exp_t exp_q[$];

   always #5 clk = ~clk;

   display_scan_ctrl #(
      .TICK_DIV  (4),
      .NUM_DIGITS(6)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .digits_in  (digits_in),
      .blank_lz   (blank_lz),
      .bcd_pos    (bcd_pos),
      .bcd_digit  (bcd_digit),
      .blank      (blank),
      .frame_start(frame_start)
   );

   task automatic push_one(input logic [3:0] p, input logic [3:0] dg,
                           input logic b, input logic f, input int w);
      exp_t e;
      e.pos = p; e.dig = dg; e.blk = b; e.fs = f; e.dwell = w;
      exp_q.push_back(e);
   endtask

   // shown: hand-written digits per position; mask: positions expected blank
   task automatic push_frame(input logic [23:0] shown, input logic [5:0] mask,
                             input int first_dwell);
      for (int i = 0; i < 6; i++) begin
         if (mask[i])
            push_one(4'hF, 4'h0, 1'b1, i == 0, (i == 0) ? first_dwell : 4);
         else
            push_one(4'(i), shown[4*i +: 4], 1'b0, i == 0,
                     (i == 0) ? first_dwell : 4);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset(input int n, input string tag);
      rst = 1'b1;
      repeat (n) begin
         @(posedge clk);
         @(negedge clk);
         total++;
         if ({bcd_pos, bcd_digit, blank, frame_start} !== 10'h0) begin
            bad++;
            $display("FAIL %s: got pos=%h dig=%h blk=%b fs=%b want all 0",
                     tag, bcd_pos, bcd_digit, blank, frame_start);
         end
      end
   endtask

   // Monitor: an event is any change of (pos,digit,blank) or a frame_start.
   initial begin
      logic [8:0] prev_t;
      logic [8:0] cur_t;
      exp_t       cur_e;
      exp_t       e;
      bit         have_cur;
      int         run;
      prev_t = '0;
      have_cur = 0;
      run = 0;
      cur_e = '0;
      forever begin
         @(posedge clk);
         #2;
         if (rst) begin
            prev_t = '0;
            have_cur = 0;
            run = 0;
         end else begin
            cur_t = {bcd_pos, bcd_digit, blank};
            if (cur_t != prev_t || frame_start) begin
               if (have_cur && cur_e.dwell != 0) begin
                  total++;
                  if (run != cur_e.dwell) begin
                     bad++;
                     $display("FAIL dwell pos=%h: got %0d cycles want %0d",
                              cur_e.pos, run, cur_e.dwell);
                  end
               end
               total++;
               if (exp_q.size() == 0) begin
                  bad++;
                  have_cur = 0;
                  $display("FAIL unexpected: got pos=%h dig=%h blk=%b fs=%b want none",
                           bcd_pos, bcd_digit, blank, frame_start);
               end else begin
                  e = exp_q.pop_front();
                  if ({cur_t, frame_start} !== {e.pos, e.dig, e.blk, e.fs}) begin
                     bad++;
                     $display("FAIL event: got pos=%h dig=%h blk=%b fs=%b want pos=%h dig=%h blk=%b fs=%b",
                              bcd_pos, bcd_digit, blank, frame_start,
                              e.pos, e.dig, e.blk, e.fs);
                  end
                  cur_e = e;
                  have_cur = 1;
               end
               run = 1;
            end else begin
               run++;
            end
            prev_t = cur_t;
         end
      end
   end

   initial begin
      // Reset hold
      digits_in = 24'h123456;
      do_reset(3, "rst_hold");

      // Basic scan over two frames
      push_frame(24'h123456, 6'b000000, 3);
      push_frame(24'h123456, 6'b000000, 4);
      push_one(4'h0, 4'h6, 1'b0, 1'b1, 0);
      rst = 1'b0;
      step(50);

      // Leading-zero blank, then blank_lz dropped mid frame 2
      do_reset(1, "rst_lz");
      digits_in = 24'h012345;
      blank_lz = 1'b1;
      push_frame(24'h012345, 6'b100000, 3);
      push_frame(24'h012345, 6'b000000, 4);
      push_one(4'h0, 4'h5, 1'b0, 1'b1, 0);
      rst = 1'b0;
      step(30);
      blank_lz = 1'b0;
      step(20);

      // Snapshot isolation
      do_reset(1, "rst_snap");
      digits_in = 24'h111111;
      push_frame(24'h111111, 6'b000000, 3);
      push_one(4'h0, 4'h2, 1'b0, 1'b1, 0);
      rst = 1'b0;
      step(10);
      digits_in = 24'h222222;
      step(16);

      // Invalid BCD always blanks
      do_reset(1, "rst_inv");
      digits_in = 24'h00A000;
      push_frame(24'h000000, 6'b001000, 3);
      push_frame(24'h000000, 6'b001000, 4);
      push_one(4'h0, 4'h0, 1'b0, 1'b1, 0);
      rst = 1'b0;
      step(50);

      // Enable dropped for 10 cycles on position 3
      do_reset(1, "rst_en");
      digits_in = 24'h123456;
      push_one(4'h0, 4'h6, 1'b0, 1'b1, 3);
      push_one(4'h1, 4'h5, 1'b0, 1'b0, 4);
      push_one(4'h2, 4'h4, 1'b0, 1'b0, 4);
      push_one(4'h3, 4'h3, 1'b0, 1'b0, 14);
      push_one(4'h4, 4'h2, 1'b0, 1'b0, 4);
      push_one(4'h5, 4'h1, 1'b0, 1'b0, 4);
      push_one(4'h0, 4'h6, 1'b0, 1'b1, 0);
      rst = 1'b0;
      step(14);
      en = 1'b0;
      step(10);
      en = 1'b1;
      step(12);

      // Reset while position 4 is showing
      do_reset(1, "rst_pre");
      push_one(4'h0, 4'h6, 1'b0, 1'b1, 3);
      push_one(4'h1, 4'h5, 1'b0, 1'b0, 4);
      push_one(4'h2, 4'h4, 1'b0, 1'b0, 4);
      push_one(4'h3, 4'h3, 1'b0, 1'b0, 4);
      push_one(4'h4, 4'h2, 1'b0, 1'b0, 0);
      rst = 1'b0;
      step(18);
      do_reset(2, "rst_mid");
      push_one(4'h0, 4'h6, 1'b0, 1'b1, 3);
      push_one(4'h1, 4'h5, 1'b0, 1'b0, 4);
      push_one(4'h2, 4'h4, 1'b0, 1'b0, 0);
      rst = 1'b0;
      step(10);

      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain: got %0d events left want 0", exp_q.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
